// File: rtl/somsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package somsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int SOMSUB_N_DEF = 8;

  // Bit counter must hold 0..N-1; never narrower than one bit.
  function automatic int somsub_cnt_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/somsub_serial_celula.sv
// One-bit full adder/subtractor cell: m=0 yields carry, m=1 yields borrow on ts.
module celula_somsub (
  input  logic m,
  input  logic a,
  input  logic b,
  input  logic te,
  output logic s,
  output logic ts
);

  assign s  = a ^ b ^ te;
  assign ts = (b & te) | ((a ^ m) & (b | te));

endmodule

// File: rtl/somsub_serial.sv
// Bit-serial N-bit adder/subtractor, LSB first, valid/ready on both sides.
// Define SOMSUB_OVERFLOW_EN to add the signed overflow output V.
module somsub_serial
  import somsub_pkg::*;
#(
  parameter int N = SOMSUB_N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         M,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Ts
`ifdef SOMSUB_OVERFLOW_EN
  ,
  output logic         V
`endif
);

  localparam int CW = somsub_cnt_w(N);

  state_e         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [N-1:0]   res_sh_q, res_sh_d, s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           m_q, m_d, carry_q, carry_d, ts_q, ts_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic           cell_s, cell_ts;
  logic [N-1:0]   res_next;
`ifdef SOMSUB_OVERFLOW_EN
  logic           a_msb_q, a_msb_d, b_msb_q, b_msb_d, v_q, v_d;
`endif

  celula_somsub u_cell (
    .m  (m_q),
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .te (carry_q),
    .s  (cell_s),
    .ts (cell_ts)
  );

  assign res_next = {cell_s, res_sh_q[N-1:1]};

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    m_d         = m_q;
    carry_d     = carry_q;
    ts_d        = ts_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SOMSUB_OVERFLOW_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    v_d         = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d     = A;
          b_sh_d     = B;
          m_d        = M;
          carry_d    = 1'b0;
          cnt_d      = '0;
          res_sh_d   = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
`ifdef SOMSUB_OVERFLOW_EN
          a_msb_d    = A[N-1];
          b_msb_d    = B[N-1];
`endif
        end
      end
      CALC: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        carry_d  = cell_ts;
        cnt_d    = cnt_q + CW'(1);
        // Visible outputs are loaded only on the last bit.
        if (cnt_q == CW'(N - 1)) begin
          s_d         = res_next;
          ts_d        = cell_ts;
          out_valid_d = 1'b1;
          state_d     = HOLD;
`ifdef SOMSUB_OVERFLOW_EN
          v_d = m_q ? ((a_msb_q != b_msb_q) && (cell_s != a_msb_q))
                    : ((a_msb_q == b_msb_q) && (cell_s != a_msb_q));
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      ts_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SOMSUB_OVERFLOW_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      v_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      m_q         <= m_d;
      carry_q     <= carry_d;
      ts_q        <= ts_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SOMSUB_OVERFLOW_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      v_q         <= v_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Ts        = ts_q;
`ifdef SOMSUB_OVERFLOW_EN
  assign V         = v_q;
`endif

endmodule

// File: tb/tb_somsub_serial.sv
// Scoreboard bench for somsub_serial; handles the SOMSUB_OVERFLOW_EN build too.
module tb_somsub_serial;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] s;
    logic         ts;
    logic         v;
    bit           chk_lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         M = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         Ts;
`ifdef SOMSUB_OVERFLOW_EN
  logic         V;
`endif

  logic rdy_dir  = 1'b1;
  logic rnd_rdy  = 1'b1;
  logic rand_rdy = 1'b0;
  assign out_ready = rand_rdy ? rnd_rdy : rdy_dir;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  somsub_serial #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M         (M),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Ts        (Ts)
`ifdef SOMSUB_OVERFLOW_EN
    ,
    .V         (V)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: a handshake is observed at negedge and completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("S", 32'(S), 32'(e.s));
        check("Ts", 32'(Ts), 32'(e.ts));
`ifdef SOMSUB_OVERFLOW_EN
        check("V", 32'(V), 32'(e.v));
`endif
        if (e.chk_lat) check("latency", 32'(cyc + 1 - e.acc), 32'(N + 1));
      end
    end
  end

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
    exp_t e;
    logic [N:0] sum;
    if (m) begin
      e.s  = a - b;
      e.ts = (a < b);
      e.v  = (a[N-1] != b[N-1]) && (e.s[N-1] != a[N-1]);
    end else begin
      sum  = {1'b0, a} + {1'b0, b};
      e.s  = sum[N-1:0];
      e.ts = sum[N];
      e.v  = (a[N-1] == b[N-1]) && (e.s[N-1] != a[N-1]);
    end
    e.chk_lat = 1'b0;
    e.acc = 0;
    return e;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                      input logic [N-1:0] xs, input logic xts, input logic xv, input bit lat);
    int t = 0;
    exp_t e;
    A = a; B = b; M = m; in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.s = xs; e.ts = xts; e.v = xv; e.chk_lat = lat; e.acc = cyc + 1;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 400) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 400) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish, failures %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_Ts", 32'(Ts), 32'd0);
`ifdef SOMSUB_OVERFLOW_EN
    check("rst_V", 32'(V), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0, 1'b1);
    send(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b1);
    send(8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b1, 1'b1);
    send(8'd5,   8'd3,   1'b1, 8'd2,   1'b0, 1'b0, 1'b1);
    send(8'd3,   8'd5,   1'b1, 8'd254, 1'b1, 1'b0, 1'b1);
    send(8'd128, 8'd1,   1'b1, 8'd127, 1'b0, 1'b1, 1'b1);
    send(8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0, 1'b1);
    send(8'd0,   8'd0,   1'b1, 8'd0,   1'b0, 1'b0, 1'b1);
    wait_idle();

    // Backpressure: result must sit still while out_ready is low.
    rdy_dir = 1'b0;
    send(8'd50, 8'd60, 1'b0, 8'd110, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk); t++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_S", 32'(S), 32'd110);
      check("bp_Ts", 32'(Ts), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    rdy_dir = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    wait_idle();

    // New requests during CALC are ignored; operands were latched at accept.
    send(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0, 1'b1);
    A = 8'd1; B = 8'd1; M = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("calc_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset mid-CALC aborts with no result.
    send(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_S", 32'(S), 32'd0);
    check("abort_Ts", 32'(Ts), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd7, 8'd2, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Reference-model sweep with throttled consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] ra, rb;
      logic rm;
      ra = N'($urandom);
      rb = N'($urandom);
      rm = 1'($urandom_range(0, 1));
      e = model(ra, rb, rm);
      send(ra, rb, rm, e.s, e.ts, e.v, 1'b0);
    end
    wait_idle();
    rand_rdy = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
